// File: rtl/mix_pkg.sv
// Shared types and constants for the mixing-round datapath and its consumers.
// The rotl helper backs the per-frame rotate-xor signature.
package mix_pkg;

    localparam int NWORDS  = 8;
    localparam int WIDTH   = 32;
    localparam int ROT     = 5;
    localparam int IDX_W   = $clog2(NWORDS);
    localparam int FRAME_W = NWORDS * WIDTH;

    typedef logic [WIDTH-1:0]   word_t;
    typedef logic [FRAME_W-1:0] frame_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_TWO   = 2'd2
    } fifo_state_t;

    function automatic word_t rotl(input word_t w, input int n);
        int s;
        s = n % WIDTH;
        if (s == 0) begin
            return w;
        end
        return (w << s) | (w >> (WIDTH - s));
    endfunction

endpackage

// File: rtl/mix_word_serializer_if.sv
// Frame-in / word-out stream bundle of the serializer.
// Both sides are valid/ready: a transfer happens on any posedge where valid and
// ready are both 1; the source holds valid and its payload until that transfer.
interface mix_word_serializer_if;
    import mix_pkg::*;

    logic   in_valid;
    logic   in_ready;
    frame_t in_data;
    logic   out_valid;
    logic   out_ready;
    word_t  out_data;
    idx_t   out_idx;
    logic   out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/mix_frame_fifo.sv
// Two-entry frame buffer. slot0 is always the head; a pop from TWO shifts
// slot1 down so the next frame is presented on the following cycle.
module mix_frame_fifo
    import mix_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  frame_t      push_data,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output frame_t      head,
    output fifo_state_t state
);

    frame_t slot0;
    frame_t slot1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FIFO_EMPTY;
        end else begin
            case (state)
                FIFO_EMPTY: begin
                    if (push) begin
                        slot0 <= push_data;
                        state <= FIFO_ONE;
                    end
                end
                FIFO_ONE: begin
                    // Push+pop replaces the head in place and occupancy is unchanged.
                    if (push && pop) begin
                        slot0 <= push_data;
                    end else if (push) begin
                        slot1 <= push_data;
                        state <= FIFO_TWO;
                    end else if (pop) begin
                        state <= FIFO_EMPTY;
                    end
                end
                FIFO_TWO: begin
                    if (pop) begin
                        slot0 <= slot1;
                        state <= FIFO_ONE;
                    end
                end
                default: state <= FIFO_EMPTY;
            endcase
        end
    end

    assign full  = (state == FIFO_TWO);
    assign empty = (state == FIFO_EMPTY);
    assign head  = slot0;

endmodule

// File: rtl/mix_word_serializer.sv
// Streams buffered 8-word mixing-state frames one word per beat and folds each
// frame into a rotate-xor signature; also counts completed frames.
module mix_word_serializer
    import mix_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mix_word_serializer_if.slave bus,
    output word_t                sig,
    output logic                 sig_valid,
    output logic [31:0]          frame_cnt,
    output fifo_state_t          state
);

    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    frame_t      head;
    idx_t        idx;
    word_t       acc;
    word_t       acc_next;
    logic        beat;
    logic        last_beat;
    logic [31:0] frame_cnt_q;

    mix_frame_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.in_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head),
        .state     (state)
    );

    // in_ready deliberately ignores this cycle's pop so it never depends on out_ready.
    assign bus.in_ready  = !rst && !full;
    assign push          = bus.in_valid && bus.in_ready;

    assign bus.out_valid = !empty;
    assign bus.out_data  = head[int'(idx) * WIDTH +: WIDTH];
    assign bus.out_idx   = idx;
    assign bus.out_last  = (idx == idx_t'(NWORDS - 1));

    assign beat      = bus.out_valid && bus.out_ready;
    assign last_beat = beat && bus.out_last;
    assign pop       = last_beat;
    assign acc_next  = rotl(acc, ROT) ^ bus.out_data;
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            acc         <= '0;
            sig         <= '0;
            sig_valid   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            sig_valid <= 1'b0;
            if (last_beat) begin
                idx         <= '0;
                acc         <= '0;
                sig         <= acc_next;
                sig_valid   <= 1'b1;
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end else if (beat) begin
                idx <= idx + 1'b1;
                acc <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_mix_word_serializer.sv
// Directed bench for mix_word_serializer: streaming, backpressure, full buffer,
// mid-frame reset and frame counter wrap, with hand-computed expectations.
module tb_mix_word_serializer;
    import mix_pkg::*;

    logic        clk;
    logic        rst;
    word_t       sig;
    logic        sig_valid;
    logic [31:0] frame_cnt;
    fifo_state_t state;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] SIG_SEQ = 32'h443214C7;

    mix_word_serializer_if bus ();

    mix_word_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .sig       (sig),
        .sig_valid (sig_valid),
        .frame_cnt (frame_cnt),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic frame_t seq_frame();
        frame_t f;
        for (int k = 0; k < NWORDS; k++) f[k*WIDTH +: WIDTH] = word_t'(k);
        return f;
    endfunction

    function automatic frame_t const_frame(input word_t w);
        frame_t f;
        for (int k = 0; k < NWORDS; k++) f[k*WIDTH +: WIDTH] = w;
        return f;
    endfunction

    // Checks the word on the output port, then lets one beat happen.
    task automatic expect_beat(input string tag, input word_t d, input int i);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".data"},  bus.out_data, d);
        chk({tag, ".idx"},   32'(bus.out_idx), 32'(i));
        chk({tag, ".last"},  32'(bus.out_last), 32'(i == NWORDS - 1));
        tick();
    endtask

    task automatic push_frame(input frame_t f);
        bus.in_valid = 1'b1;
        bus.in_data  = f;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.in_ready",  32'(bus.in_ready), 32'd0);
        chk("rst.frame_cnt", frame_cnt, 32'd0);
        chk("rst.sig",       sig, 32'd0);
        chk("rst.sig_valid", 32'(sig_valid), 32'd0);
        chk("rst.state",     32'(state), 32'(FIFO_EMPTY));
        rst = 1'b0;
        #1;
        chk("rst.in_ready_after", 32'(bus.in_ready), 32'd1);

        // 1: single frame, sink always ready
        bus.out_ready = 1'b1;
        push_frame(seq_frame());
        for (int k = 0; k < NWORDS; k++) begin
            chk("t1.sig_valid_low", 32'(sig_valid), 32'd0);
            expect_beat("t1", word_t'(k), k);
        end
        chk("t1.sig",       sig, SIG_SEQ);
        chk("t1.sig_valid", 32'(sig_valid), 32'd1);
        chk("t1.frame_cnt", frame_cnt, 32'd1);
        chk("t1.out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t1.sig_pulse_end", 32'(sig_valid), 32'd0);

        // 2: backpressure at idx 2
        bus.out_ready = 1'b0;
        push_frame(seq_frame());
        bus.out_ready = 1'b1;
        expect_beat("t2", 32'd0, 0);
        expect_beat("t2", 32'd1, 1);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("t2.hold_data", bus.out_data, 32'd2);
            chk("t2.hold_idx",  32'(bus.out_idx), 32'd2);
            chk("t2.in_ready",  32'(bus.in_ready), 32'd1);
            chk("t2.state",     32'(state), 32'(FIFO_ONE));
            chk("t2.sig_held",  sig, SIG_SEQ);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 2; k < NWORDS; k++) expect_beat("t2", word_t'(k), k);
        chk("t2.sig",       sig, SIG_SEQ);
        chk("t2.frame_cnt", frame_cnt, 32'd2);

        // 3/4: fill both slots, hold a third frame on in_valid
        bus.out_ready = 1'b0;
        push_frame(const_frame(32'h11111111));
        chk("t3.in_ready_one", 32'(bus.in_ready), 32'd1);
        push_frame(const_frame(32'h22222222));
        chk("t3.in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("t3.state",         32'(state), 32'(FIFO_TWO));
        bus.in_valid  = 1'b1;
        bus.in_data   = const_frame(32'h33333333);
        bus.out_ready = 1'b1;
        for (int k = 0; k < NWORDS; k++) begin
            chk("t4.in_ready_blocked", 32'(bus.in_ready), 32'd0);
            expect_beat("t3.a", 32'h11111111, k);
        end
        chk("t3.sig_a",       sig, 32'd0);
        chk("t3.sig_valid_a", 32'(sig_valid), 32'd1);
        chk("t3.cnt_a",       frame_cnt, 32'd3);
        chk("t4.in_ready_open", 32'(bus.in_ready), 32'd1);
        expect_beat("t3.b", 32'h22222222, 0);
        bus.in_valid = 1'b0;
        chk("t4.state_refull", 32'(state), 32'(FIFO_TWO));
        for (int k = 1; k < NWORDS; k++) expect_beat("t3.b", 32'h22222222, k);
        chk("t3.cnt_b", frame_cnt, 32'd4);
        for (int k = 0; k < NWORDS; k++) expect_beat("t4.c", 32'h33333333, k);
        chk("t4.cnt_c",     frame_cnt, 32'd5);
        chk("t4.empty",     32'(bus.out_valid), 32'd0);
        chk("t4.state_end", 32'(state), 32'(FIFO_EMPTY));

        // 5: reset at idx 4, with a push offered during reset
        push_frame(seq_frame());
        for (int k = 0; k < 4; k++) expect_beat("t5.pre", word_t'(k), k);
        chk("t5.idx4", 32'(bus.out_idx), 32'd4);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = const_frame(32'h55555555);
        #1;
        chk("t5.in_ready_rst", 32'(bus.in_ready), 32'd0);
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5.out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5.frame_cnt", frame_cnt, 32'd0);
        chk("t5.sig",       sig, 32'd0);
        chk("t5.idx",       32'(bus.out_idx), 32'd0);
        chk("t5.state",     32'(state), 32'(FIFO_EMPTY));
        push_frame(seq_frame());
        for (int k = 0; k < NWORDS; k++) expect_beat("t5.post", word_t'(k), k);
        chk("t5.sig_again", sig, SIG_SEQ);
        chk("t5.cnt_again", frame_cnt, 32'd1);

        // 6: frame counter wrap
        force dut.frame_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.frame_cnt_q;
        #1;
        chk("t6.preload", frame_cnt, 32'hFFFFFFFF);
        push_frame(seq_frame());
        for (int k = 0; k < NWORDS; k++) expect_beat("t6", word_t'(k), k);
        chk("t6.wrap", frame_cnt, 32'd0);
        chk("t6.sig",  sig, SIG_SEQ);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
